// File: rtl/calc_pkg.sv
// Shared constants for the calc block and its result receiver.
// Occupancy classes used by the receive FIFO control.
package calc_pkg;

    localparam int DATA_W   = 32;
    localparam int RX_DEPTH = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

endpackage

// File: rtl/calc_rx_mem.sv
// Result FIFO storage: one synchronous write port,
// one combinational read port, no reset on the array.
module calc_rx_mem
    import calc_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/calc_result_rx.sv
// Receive FIFO for calc results: pointers, occupancy,
// afull/overflow flags and the downstream handshake.
module calc_result_rx
    import calc_pkg::*;
#(
    parameter int DEPTH        = RX_DEPTH,
    parameter int AFULL_MARGIN = 2,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Z,
    input  logic              pushZ,
    output logic [DATA_W-1:0] outZ,
    output logic              pushO,
    input  logic              stopO,
    output logic              afull,
    output logic              overflow,
    output logic [CW-1:0]     count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_MARGIN);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;

    occ_e          occ;
    logic          push;
    logic          pop;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        occ     = OCC_PARTIAL;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == FULL_CNT) begin
            occ = OCC_FULL;
        end
        pop  = (occ != OCC_EMPTY) && !stopO;
        // A full FIFO still accepts when the head leaves on the same edge.
        push = pushZ && ((occ != OCC_FULL) || pop);
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d   = ovf_q | (pushZ && !push);
        afull_d = (count_d >= AFULL_TH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    calc_rx_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push && !rst),
        .waddr(wptr_q),
        .wdata(Z),
        .raddr(rptr_q),
        .rdata(rd_data)
    );

    assign pushO    = (count_q != '0);
    assign outZ     = pushO ? rd_data : '0;
    assign afull    = afull_q;
    assign overflow = ovf_q;
    assign count    = count_q;

endmodule

// File: tb/tb_calc_result_rx.sv
// Bench for calc_result_rx: queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_calc_result_rx;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   Z = '0;
    logic          pushZ = 1'b0;
    logic [31:0]   outZ;
    logic          pushO;
    logic          stopO = 1'b0;
    logic          afull;
    logic          overflow;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] mq[$];
    bit          m_ovf = 1'b0;
    bit          m_afull = 1'b0;
    logic [31:0] log_q[$];
    logic [31:0] sent[$];

    calc_result_rx #(
        .DEPTH(DEPTH),
        .AFULL_MARGIN(MARGIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Z(Z),
        .pushZ(pushZ),
        .outZ(outZ),
        .pushO(pushO),
        .stopO(stopO),
        .afull(afull),
        .overflow(overflow),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a plain queue of accepted words.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_afull = 1'b0;
        end else begin
            int  sz;
            bit  take;
            sz   = mq.size();
            take = (sz != 0) && !stopO;
            if (take) begin
                log_q.push_back(outZ);
                void'(mq.pop_front());
            end
            if (pushZ) begin
                if (sz < DEPTH || take) mq.push_back(Z);
                else m_ovf = 1'b1;
            end
            m_afull = (mq.size() >= DEPTH - MARGIN);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_pushO", {31'd0, pushO}, {31'd0, mq.size() != 0});
            chk("m_outZ", outZ, (mq.size() != 0) ? mq[0] : 32'd0);
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_afull", {31'd0, afull}, {31'd0, m_afull});
            chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    task automatic cyc(input logic pz, input logic [31:0] z,
                       input logic so, input logic r);
        pushZ = pz;
        Z     = z;
        stopO = so;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (count != 0 && n < budget) begin
            cyc(1'b0, 32'd0, 1'b0, 1'b0);
            n++;
        end
        chk("drain_done", 32'(count), 32'd0);
    endtask

    initial begin
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pushO", {31'd0, pushO}, 32'd0);
        chk("rst_outZ", outZ, 32'd0);
        chk("rst_afull", {31'd0, afull}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // Single negative word, next-cycle visibility.
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFF_FFF6, 1'b0, 1'b0);
        chk("neg_pushO", {31'd0, pushO}, 32'd1);
        chk("neg_outZ", outZ, 32'hFFFF_FFF6);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        chk("neg_pushO2", {31'd0, pushO}, 32'd0);
        chk("neg_outZ2", outZ, 32'd0);
        chk("neg_log", log_q[0], 32'hFFFF_FFF6);

        // Fill while stalled, overflow on the ninth word.
        log_q.delete();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 32'(i), 1'b1, 1'b0);
            if (i == 5) chk("afull_at5", {31'd0, afull}, 32'd0);
            if (i == 6) chk("afull_at6", {31'd0, afull}, 32'd1);
            chk("stall_hold", outZ, 32'd1);
        end
        chk("fill_count", 32'(count), 32'd8);
        cyc(1'b1, 32'd9, 1'b1, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        drain(20);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_log_n", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            chk("ovf_log", log_q[i], 32'(i + 1));

        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // Full with concurrent push and pop.
        log_q.delete();
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(100 + i), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'(200 + i), 1'b0, 1'b0);
            chk("full_count", 32'(count), 32'd8);
            chk("full_ovf", {31'd0, overflow}, 32'd0);
        end
        drain(20);
        chk("full_log_n", 32'(log_q.size()), 32'd28);
        for (int i = 0; i < 28 && i < log_q.size(); i++)
            chk("full_log", log_q[i],
                (i < 8) ? 32'(100 + i) : 32'(200 + i - 8));

        // Reset mid-operation.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(50 + i), 1'b1, 1'b0);
        chk("mid_count", 32'(count), 32'd5);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_pushO", {31'd0, pushO}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        log_q.delete();
        cyc(1'b1, 32'h0000_ABCD, 1'b0, 1'b0);
        chk("mid_first", outZ, 32'h0000_ABCD);
        drain(20);
        chk("mid_log", log_q[0], 32'h0000_ABCD);

        // Random stall traffic with afull honoured.
        log_q.delete();
        sent.delete();
        begin
            int n;
            int cycles;
            n = 0;
            cycles = 0;
            while (n < 10000 && cycles < 60000) begin
                logic        pz;
                logic [31:0] d;
                pz = !afull && ($urandom_range(0, 3) != 0);
                d  = $urandom;
                if (pz) begin
                    sent.push_back(d);
                    n++;
                end
                cyc(pz, d, $urandom_range(0, 2) == 0, 1'b0);
                cycles++;
            end
            chk("rnd_sent", 32'(n), 32'd10000);
        end
        drain(40);
        chk("rnd_ovf", {31'd0, overflow}, 32'd0);
        chk("rnd_log_n", 32'(log_q.size()), 32'(sent.size()));
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < sent.size() && i < log_q.size(); i++)
                if (log_q[i] !== sent[i]) errs++;
            chk("rnd_order", 32'(errs), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_result_rx.md
CALC_RESULT_RX -- requirements
Module: calc_result_rx

Interface
REQ-001 Parameter: DEPTH, default 8; FIFO entries; SHALL be a power of 2, at least 4.
REQ-002 Parameter: AFULL_MARGIN, default 2; free-slot threshold for the afull output.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst  in  1  reset; SHALL be synchronous and active-high.
REQ-005 Port: Z  in  32  result word from the calc block.
REQ-006 Port: pushZ  in  1  Z is valid this cycle; cannot be stalled (no stop back to the calc block).
REQ-007 Port: outZ  out  32  head-of-FIFO word.
REQ-008 Port: pushO  out  1  outZ is valid.
REQ-009 Port: stopO  in  1  downstream cannot accept this cycle.
REQ-010 Port: afull  out  1  occupancy >= DEPTH-AFULL_MARGIN; the upstream sequencer SHALL stop issuing operand triples while this is high.
REQ-011 Port: overflow  out  1  sticky flag: a pushZ word was dropped.
REQ-012 Port: count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 Input transfer SHALL occur at every rising edge with pushZ=1, except as stated in REQ-018.
REQ-014 Output transfer SHALL occur at a rising edge where pushO=1 and stopO=0; the head entry SHALL then be removed.
REQ-015 pushO SHALL equal (count!=0); outZ SHALL equal the head entry when pushO=1 and 32'd0 otherwise.
REQ-016 While pushO=1 and stopO=1, outZ and pushO SHALL hold stable until the transfer occurs.
REQ-017 Latency: a word accepted at edge N into an empty FIFO SHALL appear on outZ with pushO=1 in the cycle after edge N; there is no same-cycle bypass.
REQ-018 Full (count==DEPTH) with pushZ=1 and no output transfer: the word SHALL be dropped, contents unchanged, and overflow set to 1.
REQ-019 Full with pushZ=1 and a simultaneous output transfer: both transfers SHALL occur; count stays DEPTH; overflow unchanged.
REQ-020 Empty with pushZ=1: the word SHALL be written and count SHALL become 1; stopO is irrelevant that cycle.
REQ-021 Simultaneous input and output transfer at any occupancy SHALL leave count unchanged.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO.
REQ-023 Occupancy states: EMPTY (count 0), PARTIAL, FULL (count DEPTH). Transitions follow only from net +1, 0 or -1 per edge; no other jumps are permitted.
REQ-024 afull SHALL be a registered function of the post-edge count.
REQ-025 overflow SHALL remain 1 until rst.
REQ-026 Z data SHALL be stored unmodified; no arithmetic is performed on it. All 32 bits SHALL be preserved, including two's-complement negatives.

Reset
REQ-027 With rst=1 at an edge: count=0, pointers=0, pushO=0, outZ=0, afull=0 (given AFULL_MARGIN<DEPTH), overflow=0.
REQ-028 Reset mid-operation SHALL discard all stored words. pushZ SHALL be ignored while rst=1.
REQ-029 Storage array contents need no reset.

Structure
REQ-030 calc_pkg SHALL hold DATA_W=32 and the default RX_DEPTH=8; this block and the calc block share them.
REQ-031 One sub-module is natural: calc_rx_mem, a DEPTH x 32 dual-port register array with one write port and one combinational read port.
REQ-032 Pointer, count, flag and handshake logic SHALL reside in calc_result_rx.

Verification
REQ-033 Reset, then pushZ for one cycle with Z=32'hFFFF_FFF6, stopO=0 -> the next cycle shows pushO=1 and outZ=32'hFFFF_FFF6; the cycle after that shows pushO=0 and outZ=0.
REQ-034 stopO=1, then 8 pushZ words 1..8 -> count=8 and afull=1 from a count of 6; a 9th push (value 9) -> overflow=1 and count stays 8; release stopO -> outZ sequence is 1..8 only.
REQ-035 Full FIFO with stopO=0 and pushZ=1 held for 20 cycles -> count stays 8, overflow stays 0, and output order matches input order.
REQ-036 Toggle stopO randomly for 10^4 words with a reference queue in the bench -> all words match in order and overflow=0 when afull is honoured.
REQ-037 Fill to 5 entries, assert rst for one cycle -> count=0, pushO=0, overflow=0; the next word pushed is the first one output.
